mem_router: RTL and testbench
=============================

MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requester ports (port 0 = instruction fetch, 1 = data).
REQ-002 SHALL have parameter N_REGIONS, default 2, number of target memory regions.
REQ-003 SHALL have parameter REGION_BASE, default {32'h0000_0100, 32'h0000_0000}, per-region base address.
REQ-004 SHALL have parameter REGION_MASK, default {32'hFE00_0000, 32'hFFFF_FF00}, per-region decode mask.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, maximum target wait cycles before an error response.
REQ-006 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_enable  in  N_PORTS  request level per port
- req_addr  in  N_PORTS x 32  byte address
- req_we  in  N_PORTS  write enable
- req_oplen  in  N_PORTS x 2  access length (00 byte, 01 half, 10 three-byte, 11 word)
- req_unsigned  in  N_PORTS  zero-extend read data
- req_wdata  in  N_PORTS x 32  write data
- resp_valid  out  N_PORTS  one-cycle completion pulse
- resp_err  out  N_PORTS  decode or timeout error, qualified by resp_valid
- resp_rdata  out  32  extended read data, shared, qualified by resp_valid
- tgt_enable  out  N_REGIONS  request level per region
- tgt_addr  out  32  region offset (req_addr AND NOT mask)
- tgt_we  out  1
- tgt_oplen  out  2
- tgt_wdata  out  32
- tgt_valid  in  N_REGIONS  target completion
- tgt_rdata  in  N_REGIONS x 32  target read data
REQ-007 Clock is clk; reset is rst, synchronous, active-high.

Function
REQ-008 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, plus IDLE -> RESP on decode miss.
REQ-009 In IDLE, SHALL grant round-robin among asserted req_enable, starting at rr_ptr; rr_ptr becomes grant+1 mod N_PORTS at grant.
REQ-010 Decode: region r matches when (addr AND REGION_MASK[r]) == REGION_BASE[r]; the lowest matching index wins.
REQ-011 At grant, SHALL register addr, we, oplen, unsigned, wdata, port and region; the request is committed even if req_enable later drops.
REQ-012 In WAIT, SHALL hold tgt_enable[region] high and tgt_* stable until tgt_valid[region]; all other tgt_enable bits are 0.
REQ-013 On tgt_valid, SHALL capture tgt_rdata[region], drop tgt_enable in the next cycle, and enter RESP.
REQ-014 In RESP, SHALL pulse resp_valid[port] for exactly one cycle with resp_rdata sign- or zero-extended from oplen; writes return rdata 0.
REQ-015 On a decode miss, SHALL issue no target access and pulse resp_valid and resp_err on the port.
REQ-016 Wait counter: cleared at grant, +1 per WAIT cycle; on reaching TIMEOUT_CYC, SHALL drop tgt_enable and respond with resp_err=1, rdata 0.
REQ-017 Latency: enable sampled at edge N -> tgt_enable high after N; tgt_valid at edge M -> resp_valid high during the cycle after M; the minimum round-trip is 3 cycles.
REQ-018 Only one request is in flight; requesters hold req_enable and see no grant until the preceding RESP ends.
REQ-019 A port still asserting enable in the cycle after its resp_valid SHALL be treated as a new request.

Reset
REQ-020 On rst, SHALL go to IDLE with rr_ptr=0, counter=0, and all outputs 0, including any in-flight request, which is dropped without response.

Structure
REQ-021 Package mem_router_pkg SHALL hold the oplen enum, state enum and sign-extension function.
REQ-022 Sub-module mem_sext (32-bit in, unsigned, oplen -> 32-bit out) SHALL be instantiated once.

Verification
REQ-023 Port 1 reads byte 0x80 at 0x10 (region 0), unsigned=0 -> resp_rdata 0xFFFFFF80; with unsigned=1 -> 0x00000080.
REQ-024 Both ports request continuously after reset -> grants alternate 0,1,0,1; no port is starved.
REQ-025 Address 0x0000_0104 -> tgt_enable[1], tgt_addr 0x04; address 0x4000_0000 -> resp_err=1 with no tgt_enable.
REQ-026 Target never answers, TIMEOUT_CYC=8 -> tgt_enable high 8 cycles, then resp_valid with resp_err=1.
REQ-027 rst asserted during WAIT -> the next cycle has all outputs 0, and a later request completes normally.

Source files
------------

// File: rtl/mem_router_pkg.sv
// Shared types and helpers for the memory router: access-length and FSM state
// encodings plus the read-data extension function.
package mem_router_pkg;

    typedef enum logic [1:0] {
        OP_BYTE = 2'b00,
        OP_HALF = 2'b01,
        OP_TRI  = 2'b10,
        OP_WORD = 2'b11
    } oplen_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Extends the low 1..4 bytes of din to 32 bits, zero- or sign-filled.
    function automatic logic [DATA_W-1:0] sext_data(input logic [DATA_W-1:0] din,
                                                    input logic              is_unsigned,
                                                    input oplen_t            oplen);
        logic [DATA_W-1:0] dout;
        dout = din;
        case (oplen)
            OP_BYTE: dout = {{24{~is_unsigned & din[7]}},  din[7:0]};
            OP_HALF: dout = {{16{~is_unsigned & din[15]}}, din[15:0]};
            OP_TRI:  dout = {{8{~is_unsigned & din[23]}},  din[23:0]};
            default: dout = din;
        endcase
        return dout;
    endfunction

endpackage

// File: rtl/mem_sext.sv
// Read-data extension stage: selects 1, 2, 3 or 4 low bytes and zero- or
// sign-extends them to a full word.
module mem_sext
    import mem_router_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic              is_unsigned,
    input  logic [1:0]        oplen,
    output logic [DATA_W-1:0] dout
);

    assign dout = sext_data(din, is_unsigned, oplen_t'(oplen));

endmodule

// File: rtl/mem_router.sv
// Memory router: round-robin arbitration of requester ports onto address-decoded
// target regions, one transaction in flight, with timeout and read-data extension.
module mem_router
    import mem_router_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int N_REGIONS = 2,
    parameter logic [N_REGIONS-1:0][31:0] REGION_BASE = {32'h0000_0100, 32'h0000_0000},
    parameter logic [N_REGIONS-1:0][31:0] REGION_MASK = {32'hFE00_0000, 32'hFFFF_FF00},
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         req_enable,
    input  logic [N_PORTS-1:0][31:0]   req_addr,
    input  logic [N_PORTS-1:0]         req_we,
    input  logic [N_PORTS-1:0][1:0]    req_oplen,
    input  logic [N_PORTS-1:0]         req_unsigned,
    input  logic [N_PORTS-1:0][31:0]   req_wdata,
    output logic [N_PORTS-1:0]         resp_valid,
    output logic [N_PORTS-1:0]         resp_err,
    output logic [31:0]                resp_rdata,
    output logic [N_REGIONS-1:0]       tgt_enable,
    output logic [31:0]                tgt_addr,
    output logic                       tgt_we,
    output logic [1:0]                 tgt_oplen,
    output logic [31:0]                tgt_wdata,
    input  logic [N_REGIONS-1:0]       tgt_valid,
    input  logic [N_REGIONS-1:0][31:0] tgt_rdata,
    output state_t                     dbg_state
);

    // Handshake: a requester holds req_enable (and its request fields) until it sees
    // its one-cycle resp_valid; the request is captured at grant, so fields may change
    // afterwards. Toward the target, tgt_enable and tgt_* stay stable until tgt_valid
    // of the selected region is sampled high, or until the wait counter times out.

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int RW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cur_port;
    logic [RW-1:0] cur_region;
    logic          cur_we;
    logic          cur_unsigned;
    oplen_t        cur_oplen;
    logic [CW-1:0] wait_cnt;

    logic          grant_found;
    logic [PW-1:0] grant_port;
    logic [PW-1:0] rr_next;
    logic [PW-1:0] scan_idx;
    logic          dec_hit;
    logic [RW-1:0] dec_region;
    logic [31:0]   sel_addr;
    logic          tgt_done;
    logic [31:0]   tgt_sel_rdata;
    logic [31:0]   ext_rdata;

    assign dbg_state = state;

    // Scan from the highest offset down so the port nearest rr_ptr wins last.
    always_comb begin
        grant_found = 1'b0;
        grant_port  = '0;
        scan_idx    = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            scan_idx = PW'((int'(rr_ptr) + i) % N_PORTS);
            if (req_enable[scan_idx]) begin
                grant_found = 1'b1;
                grant_port  = scan_idx;
            end
        end
        rr_next = PW'((int'(grant_port) + 1) % N_PORTS);
    end

    assign sel_addr = req_addr[grant_port];

    // Lowest matching region index has priority.
    always_comb begin
        dec_hit    = 1'b0;
        dec_region = '0;
        for (int r = N_REGIONS - 1; r >= 0; r--) begin
            if ((sel_addr & REGION_MASK[RW'(r)]) == REGION_BASE[RW'(r)]) begin
                dec_hit    = 1'b1;
                dec_region = RW'(r);
            end
        end
    end

    assign tgt_done      = tgt_valid[cur_region];
    assign tgt_sel_rdata = tgt_rdata[cur_region];

    mem_sext u_sext (
        .din         (tgt_sel_rdata),
        .is_unsigned (cur_unsigned),
        .oplen       (cur_oplen),
        .dout        (ext_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            cur_port     <= '0;
            cur_region   <= '0;
            cur_we       <= 1'b0;
            cur_unsigned <= 1'b0;
            cur_oplen    <= OP_BYTE;
            wait_cnt     <= '0;
            resp_valid   <= '0;
            resp_err     <= '0;
            resp_rdata   <= '0;
            tgt_enable   <= '0;
            tgt_addr     <= '0;
            tgt_we       <= 1'b0;
            tgt_oplen    <= '0;
            tgt_wdata    <= '0;
        end else begin
            resp_valid <= '0;
            resp_err   <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        rr_ptr       <= rr_next;
                        wait_cnt     <= '0;
                        cur_port     <= grant_port;
                        cur_we       <= req_we[grant_port];
                        cur_unsigned <= req_unsigned[grant_port];
                        cur_oplen    <= oplen_t'(req_oplen[grant_port]);
                        if (dec_hit) begin
                            cur_region             <= dec_region;
                            tgt_enable             <= '0;
                            tgt_enable[dec_region] <= 1'b1;
                            tgt_addr               <= sel_addr & ~REGION_MASK[dec_region];
                            tgt_we                 <= req_we[grant_port];
                            tgt_oplen              <= req_oplen[grant_port];
                            tgt_wdata              <= req_wdata[grant_port];
                            state                  <= ST_WAIT;
                        end else begin
                            resp_valid[grant_port] <= 1'b1;
                            resp_err[grant_port]   <= 1'b1;
                            resp_rdata             <= '0;
                            state                  <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (tgt_done) begin
                        tgt_enable           <= '0;
                        resp_valid[cur_port] <= 1'b1;
                        resp_rdata           <= cur_we ? 32'h0 : ext_rdata;
                        state                <= ST_RESP;
                    end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        tgt_enable           <= '0;
                        resp_valid[cur_port] <= 1'b1;
                        resp_err[cur_port]   <= 1'b1;
                        resp_rdata           <= '0;
                        state                <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    resp_rdata <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: directed transfers, a target model with
// programmable latency, and scoreboards for responses and target accesses.
module tb_mem_router;
    import mem_router_pkg::*;

    localparam int NP = 2;
    localparam int NR = 2;
    localparam int TO = 8;
    localparam int RSW = 36;
    localparam int TW = 69;

    logic                clk;
    logic                rst;
    logic [NP-1:0]       req_enable;
    logic [NP-1:0][31:0] req_addr;
    logic [NP-1:0]       req_we;
    logic [NP-1:0][1:0]  req_oplen;
    logic [NP-1:0]       req_unsigned;
    logic [NP-1:0][31:0] req_wdata;
    logic [NP-1:0]       resp_valid;
    logic [NP-1:0]       resp_err;
    logic [31:0]         resp_rdata;
    logic [NR-1:0]       tgt_enable;
    logic [31:0]         tgt_addr;
    logic                tgt_we;
    logic [1:0]          tgt_oplen;
    logic [31:0]         tgt_wdata;
    logic [NR-1:0]       tgt_valid;
    logic [NR-1:0][31:0] tgt_rdata;
    state_t              dbg_state;

    int checks = 0;
    int errors = 0;
    logic [RSW-1:0] exp_q[$];
    logic [TW-1:0]  exp_tgt_q[$];

    logic [31:0] tgt_data = 32'h0;
    int          tgt_lat = 0;
    bit          tgt_silent = 1'b0;
    int          last_en_cycles = 0;

    // Region 1 uses mask FFFF_FF00 so that base 0x100 is reachable (0x100..0x1FF).
    mem_router #(
        .N_PORTS     (NP),
        .N_REGIONS   (NR),
        .REGION_BASE ({32'h0000_0100, 32'h0000_0000}),
        .REGION_MASK ({32'hFFFF_FF00, 32'hFFFF_FF00}),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_enable   (req_enable),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_oplen    (req_oplen),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .tgt_enable   (tgt_enable),
        .tgt_addr     (tgt_addr),
        .tgt_we       (tgt_we),
        .tgt_oplen    (tgt_oplen),
        .tgt_wdata    (tgt_wdata),
        .tgt_valid    (tgt_valid),
        .tgt_rdata    (tgt_rdata),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input int p, input logic err, input logic [31:0] data);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        exp_q.push_back({v, err ? v : NP'(0), data});
    endtask

    task automatic expect_tgt(input int r, input logic [31:0] off, input logic we,
                              input logic [1:0] op, input logic [31:0] wd);
        logic [NR-1:0] en;
        en = '0;
        en[r] = 1'b1;
        exp_tgt_q.push_back({en, off, we, op, wd});
    endtask

    task automatic issue(input int p, input logic [31:0] addr, input logic we,
                         input logic [1:0] op, input logic uns, input logic [31:0] wd,
                         output int lat);
        @(posedge clk);
        #1;
        req_addr[p]     = addr;
        req_we[p]       = we;
        req_oplen[p]    = op;
        req_unsigned[p] = uns;
        req_wdata[p]    = wd;
        req_enable[p]   = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (resp_valid[p]) break;
        end
        if (!resp_valid[p]) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: port %0d saw no resp_valid in %0d cycles, required a response", p, lat);
        end
        req_enable[p] = 1'b0;
    endtask

    task automatic xfer(input int p, input logic [31:0] addr, input logic we,
                        input logic [1:0] op, input logic uns, input logic [31:0] wd,
                        input logic [31:0] data, input int region, input logic [31:0] off,
                        input logic err, input logic [31:0] rdata, input int exp_lat,
                        input string name);
        int lat;
        tgt_data = data;
        if (region >= 0) expect_tgt(region, off, we, op, wd);
        expect_resp(p, err, rdata);
        issue(p, addr, we, op, uns, wd, lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Target model: answers the enabled region after tgt_lat idle cycles.
    initial begin
        int wcnt;
        tgt_valid = '0;
        tgt_rdata = '0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            tgt_valid = '0;
            if (tgt_enable != '0 && !tgt_silent) begin
                if (wcnt >= tgt_lat) begin
                    tgt_valid = tgt_enable;
                    for (int r = 0; r < NR; r++)
                        tgt_rdata[r] = tgt_enable[r] ? tgt_data : 32'hDEAD_BEEF;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Response scoreboard
    initial begin
        logic [RSW-1:0] e;
        forever begin
            @(negedge clk);
            if (resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got valid=%b err=%b rdata=0x%h, required no response",
                             resp_valid, resp_err, resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", 64'({resp_valid, resp_err, resp_rdata}), 64'(e));
                end
            end
        end
    end

    // Target-access scoreboard; fields are checked on every enabled cycle.
    initial begin
        logic [TW-1:0] e;
        bit active;
        bit skip;
        int en_cycles;
        active = 1'b0;
        skip = 1'b0;
        en_cycles = 0;
        e = '0;
        forever begin
            @(negedge clk);
            if (tgt_enable != '0) begin
                if (!active) begin
                    active = 1'b1;
                    en_cycles = 0;
                    skip = 1'b0;
                    if (exp_tgt_q.size() == 0) begin
                        checks++;
                        errors++;
                        skip = 1'b1;
                        $display("FAIL tgt_unexpected: got tgt_enable=%b addr=0x%h, required no target access",
                                 tgt_enable, tgt_addr);
                    end else begin
                        e = exp_tgt_q.pop_front();
                    end
                end
                en_cycles++;
                if (!skip) begin
                    check("tgt_ctl", 64'({tgt_enable, tgt_we, tgt_oplen}), 64'({e[68:67], e[34], e[33:32]}));
                    check("tgt_addr", 64'(tgt_addr), 64'(e[66:35]));
                    check("tgt_wdata", 64'(tgt_wdata), 64'(e[31:0]));
                end
            end else if (active) begin
                active = 1'b0;
                last_en_cycles = en_cycles;
            end
        end
    end

    // Main stimulus
    initial begin
        int n;
        int cyc;
        rst = 1'b1;
        req_enable = '0;
        req_addr = '0;
        req_we = '0;
        req_oplen = '0;
        req_unsigned = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctl", 64'({tgt_enable, tgt_we, tgt_oplen, resp_valid, resp_err, dbg_state}), 64'(0));
        check("rst_rdata", 64'(resp_rdata), 64'(0));
        check("rst_tgt_addr", 64'(tgt_addr), 64'(0));
        check("rst_tgt_wdata", 64'(tgt_wdata), 64'(0));

        // Read extension across lengths, both ports and both regions
        tgt_lat = 0;
        xfer(1, 32'h10, 0, 2'b00, 0, 32'h0, 32'h0000_0080, 0, 32'h10, 0, 32'hFFFF_FF80, 3, "byte_s");
        xfer(1, 32'h10, 0, 2'b00, 1, 32'h0, 32'h0000_0080, 0, 32'h10, 0, 32'h0000_0080, 3, "byte_u");
        xfer(0, 32'h24, 0, 2'b01, 0, 32'h0, 32'h1234_9A5C, 0, 32'h24, 0, 32'hFFFF_9A5C, 3, "half_s");
        xfer(0, 32'h26, 0, 2'b01, 1, 32'h0, 32'h1234_9A5C, 0, 32'h26, 0, 32'h0000_9A5C, 3, "half_u");
        xfer(1, 32'h31, 0, 2'b10, 0, 32'h0, 32'h1280_0001, 0, 32'h31, 0, 32'hFF80_0001, 3, "tri_s");
        xfer(1, 32'h31, 0, 2'b10, 1, 32'h0, 32'h1280_0001, 0, 32'h31, 0, 32'h0080_0001, 3, "tri_u");
        xfer(0, 32'hFC, 0, 2'b11, 0, 32'h0, 32'h8000_0001, 0, 32'hFC, 0, 32'h8000_0001, 3, "word_r0");
        xfer(0, 32'h7F, 0, 2'b00, 0, 32'h0, 32'h1234_567F, 0, 32'h7F, 0, 32'h0000_007F, 3, "byte_pos");
        xfer(0, 32'h104, 0, 2'b11, 0, 32'h0, 32'hCAFE_F00D, 1, 32'h04, 0, 32'hCAFE_F00D, 3, "word_r1");
        xfer(1, 32'h1F8, 1, 2'b11, 0, 32'hA5A5_5A5A, 32'h1111_2222, 1, 32'hF8, 0, 32'h0, 3, "write_r1");

        // Decode misses, including the first address past region 1
        xfer(0, 32'h4000_0000, 0, 2'b11, 0, 32'h0, 32'h7777_7777, -1, 32'h0, 1, 32'h0, 2, "miss_far");
        xfer(1, 32'h200, 0, 2'b11, 0, 32'h0, 32'h7777_7777, -1, 32'h0, 1, 32'h0, 2, "miss_edge");

        // Slowest answer that still beats the timeout
        tgt_lat = 7;
        xfer(1, 32'h40, 0, 2'b11, 0, 32'h0, 32'h5555_AAAA, 0, 32'h40, 0, 32'h5555_AAAA, 10, "lat7");
        @(negedge clk);
        check("lat7_en_cycles", 64'(last_en_cycles), 64'(8));

        // Target never answers
        tgt_silent = 1'b1;
        xfer(0, 32'h50, 0, 2'b11, 0, 32'h0, 32'h9999_9999, 0, 32'h50, 1, 32'h0, 10, "timeout");
        @(negedge clk);
        check("timeout_en_cycles", 64'(last_en_cycles), 64'(8));
        tgt_silent = 1'b0;
        tgt_lat = 0;

        // Both ports request continuously from reset: grants 0,1,0,1,0,1
        rst_pulse();
        tgt_data = 32'h1234_8765;
        for (int k = 0; k < 3; k++) begin
            expect_tgt(0, 32'h20, 0, 2'b11, 32'h0);
            expect_resp(0, 0, 32'h1234_8765);
            expect_tgt(1, 32'h30, 0, 2'b01, 32'h0);
            expect_resp(1, 0, 32'hFFFF_8765);
        end
        @(posedge clk);
        #1;
        req_addr[0] = 32'h20;  req_we[0] = 0; req_oplen[0] = 2'b11; req_unsigned[0] = 0; req_wdata[0] = 0;
        req_addr[1] = 32'h130; req_we[1] = 0; req_oplen[1] = 2'b01; req_unsigned[1] = 0; req_wdata[1] = 0;
        req_enable = 2'b11;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (resp_valid != '0) n++;
        end
        req_enable = '0;
        check("rr_count", 64'(n), 64'(6));

        // Reset while waiting on the target drops the request silently
        tgt_silent = 1'b1;
        expect_tgt(0, 32'h10, 0, 2'b11, 32'h0);
        @(posedge clk);
        #1;
        req_addr[1] = 32'h10; req_we[1] = 0; req_oplen[1] = 2'b11; req_unsigned[1] = 0; req_wdata[1] = 0;
        req_enable[1] = 1'b1;
        n = 0;
        while (n < 10 && tgt_enable == '0) begin
            @(negedge clk);
            n++;
        end
        check("rstwait_reached", 64'(tgt_enable), 64'(2'b01));
        rst = 1'b1;
        req_enable = '0;
        @(posedge clk);
        #1;
        check("rstwait_ctl", 64'({tgt_enable, tgt_we, tgt_oplen, resp_valid, resp_err, dbg_state}), 64'(0));
        check("rstwait_rdata", 64'(resp_rdata), 64'(0));
        check("rstwait_tgt_addr", 64'(tgt_addr), 64'(0));
        check("rstwait_tgt_wdata", 64'(tgt_wdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        tgt_silent = 1'b0;
        xfer(0, 32'h14, 0, 2'b11, 0, 32'h0, 32'h0BAD_F00D, 0, 32'h14, 0, 32'h0BAD_F00D, 3, "after_rst");

        repeat (5) @(negedge clk);
        check("resp_q_empty", 64'(exp_q.size()), 64'(0));
        check("tgt_q_empty", 64'(exp_tgt_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
